// File: rtl/encoder_pkg.sv
// Shared constants for the encoder scrambler stage: sync headers, legal control types,
// the /E/ error block and the scrambler / PRBS31 polynomial taps.
package encoder_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int N_TYPES = 15;
    localparam logic [N_TYPES-1:0][7:0] CTRL_TYPES = {
        8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
        8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF
    };

    // Type 0x1E followed by eight 7-bit /E/ control codes.
    localparam logic [63:0] ERR_BLK = {{8{7'h1E}}, 8'h1E};

    // x^58 + x^39 + 1 self-synchronous scrambler
    localparam int SCR_W     = 58;
    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;

    // x^31 + x^28 + 1 test pattern
    localparam int PRBS_W   = 31;
    localparam int PRBS_TAP = 28;

    function automatic logic is_legal_type(input logic [7:0] t);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_TYPES; i++)
            if (CTRL_TYPES[i] == t) hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/encoder_scr_core.sv
// One 64-bit parallel step of the x^58+x^39+1 scrambler. state[57] is the most recent
// line bit; next_state always carries the scrambled bits, even when bypassed.
module encoder_scr_core
    import encoder_pkg::*;
(
    input  logic [SCR_W-1:0] state,
    input  logic [63:0]      data,
    input  logic             bypass,
    output logic [63:0]      scr_blk,
    output logic [SCR_W-1:0] next_state
);

    logic [63:0] scr_raw;

    // Bits scrambled early in the block feed the taps of later bits in the same block.
    function automatic logic [63:0] scr_run(input logic [SCR_W-1:0] st, input logic [63:0] d);
        logic [SCR_W+63:0] h;
        h = {64'b0, st};
        for (int i = 0; i < 64; i++)
            h[SCR_W+i] = d[i] ^ h[SCR_W+i-SCR_TAP_A] ^ h[SCR_W+i-SCR_TAP_B];
        return h[SCR_W+63:SCR_W];
    endfunction

    assign scr_raw    = scr_run(state, data);
    assign scr_blk    = bypass ? data : scr_raw;
    assign next_state = scr_raw[63:64-SCR_W];

endmodule

// File: rtl/encoder_scrambler.sv
// Block check + /E/ substitution (stage 1) and 64b scrambler (stage 2), 2-cycle latency.
// Optional PRBS31 output test pattern is built only when ENC_SCR_TESTPAT_EN is defined.
module encoder_scrambler
    import encoder_pkg::*;
#(
    parameter int               CNT_W    = 16,
    parameter logic [SCR_W-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       IN_SH,
    input  logic [63:0]      IN_BLK,
    input  logic             IN_DVAL,
    input  logic             CSR_SCR_BYPASS,
    input  logic             CSR_CNT_CLR,
    input  logic             CSR_TESTPAT_ENA,
    output logic [1:0]       OUT_SH,
    output logic [63:0]      OUT_BLK,
    output logic             OUT_DVAL,
    output logic [CNT_W-1:0] CSR_INV_SH_CNT,
    output logic [CNT_W-1:0] CSR_INV_TYPE_CNT
);

    logic [1:0]       vld_pipe;
    logic [1:0]       s1_sh;
    logic [63:0]      s1_blk;
    logic             bad_sh;
    logic             bad_type;
    logic [1:0]       chk_sh;
    logic [63:0]      chk_blk;
    logic [SCR_W-1:0] scr_state;
    logic [SCR_W-1:0] scr_next;
    logic [63:0]      scr_blk;

    always_comb begin
        bad_sh   = (IN_SH == 2'b00) || (IN_SH == 2'b11);
        bad_type = (IN_SH == SH_CTRL) && !is_legal_type(IN_BLK[7:0]);
        chk_sh   = IN_SH;
        chk_blk  = IN_BLK;
        if (bad_sh || bad_type) begin
            chk_sh  = SH_CTRL;
            chk_blk = ERR_BLK;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe <= '0;
            s1_sh    <= '0;
            s1_blk   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], IN_DVAL};
            if (IN_DVAL) begin
                s1_sh  <= chk_sh;
                s1_blk <= chk_blk;
            end
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge CLK) begin
        if (RST || CSR_CNT_CLR) begin
            CSR_INV_SH_CNT   <= '0;
            CSR_INV_TYPE_CNT <= '0;
        end else if (IN_DVAL) begin
            if (bad_sh && (CSR_INV_SH_CNT != '1))
                CSR_INV_SH_CNT <= CSR_INV_SH_CNT + CNT_W'(1);
            if (bad_type && (CSR_INV_TYPE_CNT != '1))
                CSR_INV_TYPE_CNT <= CSR_INV_TYPE_CNT + CNT_W'(1);
        end
    end

    encoder_scr_core u_scr (
        .state      (scr_state),
        .data       (s1_blk),
        .bypass     (CSR_SCR_BYPASS),
        .scr_blk    (scr_blk),
        .next_state (scr_next)
    );

`ifdef ENC_SCR_TESTPAT_EN
    logic [PRBS_W-1:0] prbs_state;
    logic [PRBS_W-1:0] prbs_next;
    logic [65:0]       prbs_bits;

    // 66 serial PRBS steps per block; bit 0 lands in OUT_SH[0].
    always_comb begin
        prbs_next = prbs_state;
        prbs_bits = '0;
        for (int i = 0; i < 66; i++) begin
            prbs_bits[i] = prbs_next[PRBS_W-1] ^ prbs_next[PRBS_TAP-1];
            prbs_next    = {prbs_next[PRBS_W-2:0], prbs_bits[i]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            prbs_state <= '1;
        else if (vld_pipe[0] && CSR_TESTPAT_ENA)
            prbs_state <= prbs_next;
    end
`else
    logic testpat_unused;
    assign testpat_unused = CSR_TESTPAT_ENA;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            scr_state <= SCR_SEED;
            OUT_SH    <= '0;
            OUT_BLK   <= '0;
        end else if (vld_pipe[0]) begin
            scr_state <= scr_next;
            OUT_SH    <= s1_sh;
            OUT_BLK   <= scr_blk;
`ifdef ENC_SCR_TESTPAT_EN
            if (CSR_TESTPAT_ENA) begin
                OUT_SH  <= prbs_bits[1:0];
                OUT_BLK <= prbs_bits[65:2];
            end
`endif
        end
    end

    assign OUT_DVAL = vld_pipe[1];

endmodule

// File: tb/tb_encoder_scrambler.sv
// Randomized bench for encoder_scrambler against a bit-serial reference model.
module tb_encoder_scrambler;

    localparam logic [63:0] E_BLK = {{8{7'h1E}}, 8'h1E};
    localparam int CMAX = 65535;

    logic        CLK;
    logic        RST;
    logic [1:0]  IN_SH;
    logic [63:0] IN_BLK;
    logic        IN_DVAL;
    logic        CSR_SCR_BYPASS;
    logic        CSR_CNT_CLR;
    logic        CSR_TESTPAT_ENA;
    logic [1:0]  OUT_SH;
    logic [63:0] OUT_BLK;
    logic        OUT_DVAL;
    logic [15:0] CSR_INV_SH_CNT;
    logic [15:0] CSR_INV_TYPE_CNT;

    encoder_scrambler dut (
        .CLK(CLK), .RST(RST), .IN_SH(IN_SH), .IN_BLK(IN_BLK), .IN_DVAL(IN_DVAL),
        .CSR_SCR_BYPASS(CSR_SCR_BYPASS), .CSR_CNT_CLR(CSR_CNT_CLR),
        .CSR_TESTPAT_ENA(CSR_TESTPAT_ENA), .OUT_SH(OUT_SH), .OUT_BLK(OUT_BLK),
        .OUT_DVAL(OUT_DVAL), .CSR_INV_SH_CNT(CSR_INV_SH_CNT),
        .CSR_INV_TYPE_CNT(CSR_INV_TYPE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          hist[$];     // last 58 scrambled line bits, oldest first
    logic        m1_vld;
    logic [1:0]  m1_sh;
    logic [63:0] m1_blk;
    logic        ex_dval;
    logic [1:0]  ex_sh;
    logic [63:0] ex_blk;
    int          ex_shcnt;
    int          ex_tycnt;
`ifdef ENC_SCR_TESTPAT_EN
    bit          pq[$];       // last 31 PRBS bits, oldest first
`endif

    logic [7:0] tlist [15] = '{8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
                               8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_t(input logic [7:0] t);
        bit hit;
        hit = 0;
        foreach (tlist[i]) if (tlist[i] == t) hit = 1;
        return hit;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 58; i++) hist.push_back(1'b1);
        m1_vld = 0; m1_sh = '0; m1_blk = '0;
        ex_dval = 0; ex_sh = '0; ex_blk = '0;
        ex_shcnt = 0; ex_tycnt = 0;
`ifdef ENC_SCR_TESTPAT_EN
        pq.delete();
        for (int i = 0; i < 31; i++) pq.push_back(1'b1);
`endif
    endtask

    // Line bit n = data bit ^ line bit n-39 ^ line bit n-58.
    task automatic scr_model(input logic [63:0] d, output logic [63:0] o);
        bit b;
        for (int i = 0; i < 64; i++) begin
            b = d[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
            o[i] = b;
            hist.push_back(b);
            void'(hist.pop_front());
        end
    endtask

`ifdef ENC_SCR_TESTPAT_EN
    task automatic next_prbs(output logic [65:0] v);
        bit b;
        for (int i = 0; i < 66; i++) begin
            b = pq[0] ^ pq[3];
            v[i] = b;
            pq.push_back(b);
            void'(pq.pop_front());
        end
    endtask
`endif

    // One clock: apply inputs, advance model, check all outputs after the edge.
    task automatic step(input logic rst, input logic dval, input logic [1:0] sh,
                        input logic [63:0] blk, input logic byp, input logic clr,
                        input logic tp);
        logic [63:0] s;
        bit bsh, bty;
`ifdef ENC_SCR_TESTPAT_EN
        logic [65:0] p;
`endif
        RST = rst; IN_DVAL = dval; IN_SH = sh; IN_BLK = blk;
        CSR_SCR_BYPASS = byp; CSR_CNT_CLR = clr; CSR_TESTPAT_ENA = tp;
        if (rst) model_reset();
        else begin
            if (m1_vld) begin
                scr_model(m1_blk, s);
                ex_sh  = m1_sh;
                ex_blk = byp ? m1_blk : s;
`ifdef ENC_SCR_TESTPAT_EN
                if (tp) begin
                    next_prbs(p);
                    ex_sh  = p[1:0];
                    ex_blk = p[65:2];
                end
`endif
            end
            ex_dval = m1_vld;
            bsh = (sh == 2'b00) || (sh == 2'b11);
            bty = (sh == 2'b10) && !legal_t(blk[7:0]);
            m1_vld = dval;
            if (dval) begin
                m1_sh  = (bsh || bty) ? 2'b10 : sh;
                m1_blk = (bsh || bty) ? E_BLK : blk;
            end
            if (clr) begin
                ex_shcnt = 0; ex_tycnt = 0;
            end else if (dval) begin
                if (bsh && ex_shcnt < CMAX) ex_shcnt++;
                if (bty && ex_tycnt < CMAX) ex_tycnt++;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("dval", 64'(OUT_DVAL), 64'(ex_dval));
        chk("sh", 64'(OUT_SH), 64'(ex_sh));
        chk("blk", OUT_BLK, ex_blk);
        chk("sh_cnt", 64'(CSR_INV_SH_CNT), 64'(ex_shcnt));
        chk("type_cnt", 64'(CSR_INV_TYPE_CNT), 64'(ex_tycnt));
    endtask

    task automatic rand_block(output logic [1:0] sh, output logic [63:0] blk);
        int r;
        r = $urandom_range(0, 9);
        blk = {$urandom, $urandom};
        if (r < 6) sh = 2'b01;
        else if (r < 8) begin
            sh = 2'b10;
            if (r == 6) blk[7:0] = tlist[$urandom_range(0, 14)];
        end else sh = (r == 8) ? 2'b00 : 2'b11;
    endtask

    initial begin
        logic [1:0]  sh;
        logic [63:0] blk;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2'b11, 64'h1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // 100 back-to-back data blocks
        for (int i = 0; i < 100; i++) step(0, 1, 2'b01, {$urandom, $urandom}, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // single bad sync header
        step(0, 1, 2'b11, {$urandom, $urandom}, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("err_sh_out", 64'(OUT_SH), 64'(2'b10));
        chk("inv_sh_one", 64'(CSR_INV_SH_CNT), 64'd1);
        step(0, 0, 0, 0, 0, 0, 0);

        // illegal then legal control type
        step(0, 1, 2'b10, 64'hDEAD_BEEF_0123_4500, 0, 0, 0);
        step(0, 1, 2'b10, 64'h1122_3344_5566_771E, 1, 0, 0);
        chk("inv_type_one", 64'(CSR_INV_TYPE_CNT), 64'd1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("ctrl_pass", OUT_BLK, 64'h1122_3344_5566_771E);
        step(0, 0, 0, 0, 0, 0, 0);

        // 1-in-3 valid with random content, bypass toggling, garbage in gaps
        for (int c = 0; c < 300; c++) begin
            rand_block(sh, blk);
            step(0, (c % 3) == 0, sh, blk, ((c / 30) % 2) == 1, 0, 0);
        end

        // reset mid-stream with traffic in both stages
        for (int i = 0; i < 5; i++) begin
            rand_block(sh, blk);
            step(0, 1, sh, blk, 0, 0, 0);
        end
        step(1, 1, 2'b01, {$urandom, $urandom}, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            rand_block(sh, blk);
            step(0, 1, sh, blk, 0, 0, 0);
        end

        // counter saturation, then clear coinciding with a bad block
        for (int i = 0; i < 65536 + 5; i++) step(0, 1, 2'b00, {$urandom, $urandom}, 0, 0, 0);
        chk("sat", 64'(CSR_INV_SH_CNT), 64'hFFFF);
        step(0, 1, 2'b11, 64'h0, 0, 1, 0);
        chk("clr_prio", 64'(CSR_INV_SH_CNT), 64'd0);
        step(0, 0, 0, 0, 0, 0, 0);

`ifdef ENC_SCR_TESTPAT_EN
        for (int c = 0; c < 60; c++) begin
            rand_block(sh, blk);
            step(0, $urandom_range(0, 3) != 0, sh, blk, 0, 0, c >= 10);
        end
`endif
        for (int i = 0; i < 30; i++) begin
            rand_block(sh, blk);
            step(0, $urandom_range(0, 1) == 1, sh, blk, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
